// File: rtl/dipsw_debounce.sv
// rtl/dipsw_debounce.sv - per-bit synchronized, counted debounce of DIP switch inputs.
// Optional glitch counter enabled by DIPSW_DEBOUNCE_GLITCH_CNT_EN.
module dipsw_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic             sw_valid,
  output logic [WIDTH-1:0] sw_changed,
  input  logic             clr_glitch,
  output logic [15:0]      glitch_count
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [1:0]       init_cnt;
  logic             load_init;
  logic [WIDTH-1:0] sync1, sync2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] diff, accept, glitch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // INIT spans two full cycles after release so sync2 holds a real sample on exit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT;
      init_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    load_init = 1'b0;
    diff      = sync2 ^ sw_out;
    accept    = '0;
    glitch    = '0;
    if (state == INIT) begin
      if (init_cnt == 2'd2) begin
        state_nxt = RUN;
        load_init = 1'b1;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        accept[i] = diff[i] && (cnt[i] == CNT_MAX);
        glitch[i] = !diff[i] && (cnt[i] != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_out     <= '0;
      sw_valid   <= 1'b0;
      sw_changed <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sw_changed <= accept;
      if (load_init) begin
        sw_out   <= sync2;
        sw_valid <= 1'b1;
      end else begin
        sw_out <= sw_out ^ accept;
      end
      // a matching input, an acceptance or INIT all return the counter to zero
      for (int i = 0; i < WIDTH; i++) begin
        if (state == RUN && diff[i] && !accept[i]) cnt[i] <= cnt[i] + CNT_ONE;
        else                                       cnt[i] <= '0;
      end
    end
  end

`ifdef DIPSW_DEBOUNCE_GLITCH_CNT_EN
  logic [15:0] glitch_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             glitch_q <= 16'd0;
    else if (clr_glitch)                      glitch_q <= 16'd0;
    else if (|glitch && glitch_q != 16'hFFFF) glitch_q <= glitch_q + 16'd1;
  end

  assign glitch_count = glitch_q;
`else
  logic unused_glitch_inputs;
  assign unused_glitch_inputs = clr_glitch ^ (|glitch);
  assign glitch_count         = 16'd0;
`endif

endmodule
